// File: rtl/bsg_manycore_axil_pkg.sv
// Shared register map and AXI-Lite response codes for the manycore host FIFO register block.
package bsg_manycore_axil_pkg;

    localparam logic [15:0] TX_DATA_ADDR      = 16'h1000;
    localparam logic [15:0] TX_VACANCY_ADDR   = 16'h1010;
    localparam logic [15:0] RX_OCCUPANCY_ADDR = 16'h1018;
    localparam logic [15:0] RX_DATA_ADDR      = 16'h101C;

    typedef enum logic [1:0] {
        AXIL_OKAY   = 2'b00,
        AXIL_SLVERR = 2'b10,
        AXIL_DECERR = 2'b11
    } axil_resp_e;

    function automatic logic is_ro_addr(input logic [15:0] addr);
        return (addr == TX_VACANCY_ADDR) || (addr == RX_OCCUPANCY_ADDR) || (addr == RX_DATA_ADDR);
    endfunction

endpackage

// File: rtl/bsg_manycore_axil_word_fifo.sv
// Single-clock word FIFO with valid/ready push, valid/yumi pop and an occupancy count.
module bsg_manycore_axil_word_fifo #(
    parameter int els_p   = 32,
    parameter int width_p = 32,
    localparam int ptr_w_lp = $clog2(els_p),
    localparam int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                v_i,
    output logic                ready_o,
    output logic [width_p-1:0]  data_o,
    output logic                v_o,
    input  logic                yumi_i,
    output logic [cnt_w_lp-1:0] count_o
);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_wptr;
    logic [ptr_w_lp-1:0] r_rptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                w_push;
    logic                w_pop;

    // Full/empty come straight from the registered count, so a pop never frees space in the same cycle.
    assign ready_o = (r_count != cnt_w_lp'(els_p));
    assign v_o     = (r_count != {cnt_w_lp{1'b0}});
    assign w_push  = v_i & ready_o;
    assign w_pop   = yumi_i & v_o;
    assign data_o  = r_mem[r_rptr];
    assign count_o = r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= {ptr_w_lp{1'b0}};
            r_rptr  <= {ptr_w_lp{1'b0}};
            r_count <= {cnt_w_lp{1'b0}};
        end else begin
            if (w_push) r_wptr <= r_wptr + ptr_w_lp'(1);
            if (w_pop)  r_rptr <= r_rptr + ptr_w_lp'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_w_lp'(1);
                2'b01:   r_count <= r_count - cnt_w_lp'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_axil_fifo_regs.sv
// AXI-Lite slave that pushes written words into a TX stream and pops an RX stream on reads,
// exposing TX vacancy and RX occupancy counters.
module bsg_manycore_axil_fifo_regs
    import bsg_manycore_axil_pkg::*;
#(
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32,
    parameter int tx_fifo_els_p     = 32,
    parameter int rx_fifo_els_p     = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [axil_addr_width_p-1:0] s_axil_awaddr_i,
    input  logic                         s_axil_awvalid_i,
    output logic                         s_axil_awready_o,
    input  logic [axil_data_width_p-1:0] s_axil_wdata_i,
    input  logic [3:0]                   s_axil_wstrb_i,
    input  logic                         s_axil_wvalid_i,
    output logic                         s_axil_wready_o,
    output logic [1:0]                   s_axil_bresp_o,
    output logic                         s_axil_bvalid_o,
    input  logic                         s_axil_bready_i,
    input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
    input  logic                         s_axil_arvalid_i,
    output logic                         s_axil_arready_o,
    output logic [axil_data_width_p-1:0] s_axil_rdata_o,
    output logic [1:0]                   s_axil_rresp_o,
    output logic                         s_axil_rvalid_o,
    input  logic                         s_axil_rready_i,
    output logic [31:0]                  tx_data_o,
    output logic                         tx_v_o,
    input  logic                         tx_ready_i,
    input  logic [31:0]                  rx_data_i,
    input  logic                         rx_v_i,
    output logic                         rx_ready_o
);

    localparam int TXC_W = $clog2(tx_fifo_els_p + 1);
    localparam int RXC_W = $clog2(rx_fifo_els_p + 1);
    localparam logic [TXC_W-1:0] TX_ELS_C = TXC_W'(tx_fifo_els_p);

    logic                         r_aw_v;
    logic [15:0]                  r_aw_addr;
    logic                         r_w_v;
    logic [axil_data_width_p-1:0] r_w_data;
    logic                         r_bvalid;
    axil_resp_e                   r_bresp;
    logic                         r_rvalid;
    axil_resp_e                   r_rresp;
    logic [axil_data_width_p-1:0] r_rdata;

    logic                         w_aw_hs;
    logic                         w_w_hs;
    logic                         w_ar_hs;
    logic                         w_commit;
    logic [15:0]                  w_wr_addr;
    logic [axil_data_width_p-1:0] w_wr_data;
    axil_resp_e                   w_bresp_n;
    axil_resp_e                   w_rresp_n;
    logic [axil_data_width_p-1:0] w_rdata_n;
    logic                         w_tx_push;
    logic                         w_tx_ready;
    logic [TXC_W-1:0]             w_tx_count;
    logic [TXC_W-1:0]             w_tx_vac;
    logic                         w_rx_v;
    logic [31:0]                  w_rx_data;
    logic                         w_rx_pop;
    logic [RXC_W-1:0]             w_rx_count;
    logic                         w_unused;

    assign w_unused = ^{s_axil_awaddr_i[axil_addr_width_p-1:16], s_axil_araddr_i[axil_addr_width_p-1:16], s_axil_wstrb_i};

    assign s_axil_awready_o = ~r_aw_v;
    assign s_axil_wready_o  = ~r_w_v;
    assign s_axil_arready_o = ~r_rvalid;
    assign s_axil_bvalid_o  = r_bvalid;
    assign s_axil_bresp_o   = r_bresp;
    assign s_axil_rvalid_o  = r_rvalid;
    assign s_axil_rresp_o   = r_rresp;
    assign s_axil_rdata_o   = r_rdata;

    assign w_aw_hs = s_axil_awvalid_i & ~r_aw_v;
    assign w_w_hs  = s_axil_wvalid_i & ~r_w_v;
    assign w_ar_hs = s_axil_arvalid_i & ~r_rvalid;

    // A channel arriving this cycle counts as held, giving AW+W -> bvalid in one cycle.
    assign w_commit  = (r_aw_v | w_aw_hs) & (r_w_v | w_w_hs) & ~r_bvalid;
    assign w_wr_addr = r_aw_v ? r_aw_addr : s_axil_awaddr_i[15:0];
    assign w_wr_data = r_w_v ? r_w_data : s_axil_wdata_i;
    assign w_tx_vac  = TX_ELS_C - w_tx_count;

    // Write address decode; a full TX FIFO drops the word instead of stalling the bus.
    always_comb begin
        w_tx_push = 1'b0;
        w_bresp_n = AXIL_OKAY;
        if (w_wr_addr == TX_DATA_ADDR) begin
            if (w_tx_ready) begin
                w_tx_push = w_commit;
                w_bresp_n = AXIL_OKAY;
            end else begin
                w_bresp_n = AXIL_SLVERR;
            end
        end else if (is_ro_addr(w_wr_addr)) begin
            w_bresp_n = AXIL_SLVERR;
        end else begin
            w_bresp_n = AXIL_DECERR;
        end
    end

    // Read address decode; values are sampled at the AR handshake.
    always_comb begin
        w_rdata_n = {axil_data_width_p{1'b0}};
        w_rresp_n = AXIL_OKAY;
        w_rx_pop  = 1'b0;
        case (s_axil_araddr_i[15:0])
            TX_VACANCY_ADDR:   w_rdata_n = {{(axil_data_width_p-TXC_W){1'b0}}, w_tx_vac};
            RX_OCCUPANCY_ADDR: w_rdata_n = {{(axil_data_width_p-RXC_W){1'b0}}, w_rx_count};
            RX_DATA_ADDR: begin
                if (w_rx_v) begin
                    w_rdata_n = w_rx_data;
                    w_rx_pop  = w_ar_hs;
                end else begin
                    w_rresp_n = AXIL_SLVERR;
                end
            end
            TX_DATA_ADDR:      w_rresp_n = AXIL_SLVERR;
            default:           w_rresp_n = AXIL_DECERR;
        endcase
    end

    // Write-channel holding registers and write response.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_aw_v    <= 1'b0;
            r_aw_addr <= 16'h0000;
            r_w_v     <= 1'b0;
            r_w_data  <= {axil_data_width_p{1'b0}};
            r_bvalid  <= 1'b0;
            r_bresp   <= AXIL_OKAY;
        end else begin
            if (w_commit)     r_aw_v <= 1'b0;
            else if (w_aw_hs) r_aw_v <= 1'b1;
            if (w_commit)     r_w_v <= 1'b0;
            else if (w_w_hs)  r_w_v <= 1'b1;
            if (w_aw_hs) r_aw_addr <= s_axil_awaddr_i[15:0];
            if (w_w_hs)  r_w_data  <= s_axil_wdata_i;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_bresp_n;
            end else if (s_axil_bready_i) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read response register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rvalid <= 1'b0;
            r_rresp  <= AXIL_OKAY;
            r_rdata  <= {axil_data_width_p{1'b0}};
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_rresp_n;
                r_rdata  <= w_rdata_n;
            end else if (s_axil_rready_i) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    bsg_manycore_axil_word_fifo #(.els_p(tx_fifo_els_p), .width_p(32)) u_tx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (w_wr_data[31:0]),
        .v_i     (w_tx_push),
        .ready_o (w_tx_ready),
        .data_o  (tx_data_o),
        .v_o     (tx_v_o),
        .yumi_i  (tx_ready_i),
        .count_o (w_tx_count)
    );

    bsg_manycore_axil_word_fifo #(.els_p(rx_fifo_els_p), .width_p(32)) u_rx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (rx_data_i),
        .v_i     (rx_v_i),
        .ready_o (rx_ready_o),
        .data_o  (w_rx_data),
        .v_o     (w_rx_v),
        .yumi_i  (w_rx_pop),
        .count_o (w_rx_count)
    );

endmodule

// File: tb/tb_bsg_manycore_axil_fifo_regs.sv
// Directed plus randomized bench; FIFO contents are modelled as queues and checked every cycle.
module tb_bsg_manycore_axil_fifo_regs;

    localparam int TX_ELS = 32;
    localparam int RX_ELS = 32;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] s_axil_awaddr_i = 32'h0;
    logic        s_axil_awvalid_i = 1'b0;
    logic        s_axil_awready_o;
    logic [31:0] s_axil_wdata_i = 32'h0;
    logic [3:0]  s_axil_wstrb_i = 4'hF;
    logic        s_axil_wvalid_i = 1'b0;
    logic        s_axil_wready_o;
    logic [1:0]  s_axil_bresp_o;
    logic        s_axil_bvalid_o;
    logic        s_axil_bready_i = 1'b1;
    logic [31:0] s_axil_araddr_i = 32'h0;
    logic        s_axil_arvalid_i = 1'b0;
    logic        s_axil_arready_o;
    logic [31:0] s_axil_rdata_o;
    logic [1:0]  s_axil_rresp_o;
    logic        s_axil_rvalid_o;
    logic        s_axil_rready_i = 1'b1;
    logic [31:0] tx_data_o;
    logic        tx_v_o;
    logic        tx_ready_i = 1'b0;
    logic [31:0] rx_data_i = 32'h0;
    logic        rx_v_i = 1'b0;
    logic        rx_ready_o;

    bsg_manycore_axil_fifo_regs dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axil_awaddr_i(s_axil_awaddr_i), .s_axil_awvalid_i(s_axil_awvalid_i), .s_axil_awready_o(s_axil_awready_o),
        .s_axil_wdata_i(s_axil_wdata_i), .s_axil_wstrb_i(s_axil_wstrb_i), .s_axil_wvalid_i(s_axil_wvalid_i),
        .s_axil_wready_o(s_axil_wready_o), .s_axil_bresp_o(s_axil_bresp_o), .s_axil_bvalid_o(s_axil_bvalid_o),
        .s_axil_bready_i(s_axil_bready_i), .s_axil_araddr_i(s_axil_araddr_i), .s_axil_arvalid_i(s_axil_arvalid_i),
        .s_axil_arready_o(s_axil_arready_o), .s_axil_rdata_o(s_axil_rdata_o), .s_axil_rresp_o(s_axil_rresp_o),
        .s_axil_rvalid_o(s_axil_rvalid_o), .s_axil_rready_i(s_axil_rready_i),
        .tx_data_o(tx_data_o), .tx_v_o(tx_v_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_v_i(rx_v_i), .rx_ready_o(rx_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    bit          chk_en = 1'b0;
    bit          pend_tx_push = 1'b0;
    logic [31:0] pend_tx_data = 32'h0;
    bit          pend_rx_pop = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, apply the queued model actions for that edge, then check the stream outputs.
    task automatic tick();
        bit          tx_pop;
        bit          rx_push;
        logic [31:0] rx_d;
        tx_pop  = tx_ready_i && (tx_q.size() > 0);
        rx_push = rx_v_i && (rx_q.size() < RX_ELS);
        rx_d    = rx_data_i;
        @(posedge clk_i); #1;
        if (tx_pop) void'(tx_q.pop_front());
        if (pend_tx_push) tx_q.push_back(pend_tx_data);
        if (pend_rx_pop) void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(rx_d);
        pend_tx_push = 1'b0;
        pend_rx_pop  = 1'b0;
        if (chk_en) begin
            check("tx_v", {31'd0, tx_v_o}, {31'd0, tx_q.size() != 0});
            if (tx_q.size() != 0) check("tx_data", tx_data_o, tx_q[0]);
            check("rx_ready", {31'd0, rx_ready_o}, {31'd0, rx_q.size() < RX_ELS});
        end
    endtask

    function automatic logic [1:0] exp_wresp(input logic [31:0] addr);
        case (addr[15:0])
            16'h1000:                   return (tx_q.size() < TX_ELS) ? 2'b00 : 2'b10;
            16'h1010, 16'h1018, 16'h101C: return 2'b10;
            default:                    return 2'b11;
        endcase
    endfunction

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input int lead, input string tag);
        bit         aw_done, w_done, aw_f, w_f, found;
        logic [1:0] exp;
        aw_done = 1'b0; w_done = 1'b0; found = 1'b0; exp = 2'b00;
        s_axil_awaddr_i = addr;
        s_axil_wdata_i  = data;
        s_axil_wstrb_i  = 4'($urandom);
        for (int cyc = 0; cyc < 20 && !(aw_done && w_done); cyc++) begin
            s_axil_awvalid_i = !aw_done;
            s_axil_wvalid_i  = !w_done && (cyc >= lead);
            aw_f = s_axil_awvalid_i && s_axil_awready_o;
            w_f  = s_axil_wvalid_i && s_axil_wready_o;
            if ((aw_done || aw_f) && (w_done || w_f)) begin
                exp = exp_wresp(addr);
                if (addr[15:0] == 16'h1000 && tx_q.size() < TX_ELS) begin
                    pend_tx_push = 1'b1;
                    pend_tx_data = data;
                end
            end
            tick();
            aw_done = aw_done | aw_f;
            w_done  = w_done | w_f;
        end
        s_axil_awvalid_i = 1'b0;
        s_axil_wvalid_i  = 1'b0;
        check({tag, "_accept"}, {31'd0, aw_done && w_done}, 32'd1);
        s_axil_bready_i = 1'b1;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (s_axil_bvalid_o) found = 1'b1;
            else tick();
        end
        check({tag, "_bvalid"}, {31'd0, found}, 32'd1);
        if (found) begin
            check({tag, "_bresp"}, {30'd0, s_axil_bresp_o}, {30'd0, exp});
            tick();
            check({tag, "_bdone"}, {31'd0, s_axil_bvalid_o}, 32'd0);
        end
    endtask

    task automatic axil_read(input logic [31:0] addr, input string tag);
        bit          fired, found, f;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        fired = 1'b0; found = 1'b0; exp_d = 32'h0; exp_r = 2'b00;
        s_axil_araddr_i = addr;
        for (int cyc = 0; cyc < 20 && !fired; cyc++) begin
            s_axil_arvalid_i = 1'b1;
            f = s_axil_arready_o;
            if (f) begin
                case (addr[15:0])
                    16'h1010: begin exp_d = TX_ELS - tx_q.size(); exp_r = 2'b00; end
                    16'h1018: begin exp_d = rx_q.size(); exp_r = 2'b00; end
                    16'h101C: begin
                        if (rx_q.size() > 0) begin
                            exp_d = rx_q[0]; exp_r = 2'b00; pend_rx_pop = 1'b1;
                        end else begin
                            exp_d = 32'h0; exp_r = 2'b10;
                        end
                    end
                    default:  begin exp_d = 32'h0; exp_r = 2'b11; end
                endcase
            end
            tick();
            fired = f;
        end
        s_axil_arvalid_i = 1'b0;
        check({tag, "_arfire"}, {31'd0, fired}, 32'd1);
        s_axil_rready_i = 1'b1;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (s_axil_rvalid_o) found = 1'b1;
            else tick();
        end
        check({tag, "_rvalid"}, {31'd0, found}, 32'd1);
        if (found) begin
            check({tag, "_rdata"}, s_axil_rdata_o, exp_d);
            check({tag, "_rresp"}, {30'd0, s_axil_rresp_o}, {30'd0, exp_r});
            tick();
            check({tag, "_rdone"}, {31'd0, s_axil_rvalid_o}, 32'd0);
        end
    endtask

    task automatic drain_tx();
        tx_ready_i = 1'b1;
        for (int cyc = 0; cyc < 200 && tx_q.size() > 0; cyc++) tick();
        check("drain_empty", {31'd0, tx_v_o}, 32'd0);
        tx_ready_i = 1'b0;
    endtask

    task automatic rx_push(input logic [31:0] data);
        rx_v_i    = 1'b1;
        rx_data_i = data;
        tick();
        rx_v_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] occ;
        // Reset state
        reset_i = 1'b1;
        tick(); tick();
        check("rst_awready", {31'd0, s_axil_awready_o}, 32'd1);
        check("rst_wready",  {31'd0, s_axil_wready_o},  32'd1);
        check("rst_arready", {31'd0, s_axil_arready_o}, 32'd1);
        check("rst_bvalid",  {31'd0, s_axil_bvalid_o},  32'd0);
        check("rst_rvalid",  {31'd0, s_axil_rvalid_o},  32'd0);
        check("rst_bresp",   {30'd0, s_axil_bresp_o},   32'd0);
        check("rst_rresp",   {30'd0, s_axil_rresp_o},   32'd0);
        check("rst_rdata",   s_axil_rdata_o,            32'd0);
        check("rst_tx_v",    {31'd0, tx_v_o},           32'd0);
        check("rst_rx_ready", {31'd0, rx_ready_o},      32'd1);
        reset_i = 1'b0;
        chk_en  = 1'b1;
        tick();

        // Single write with AW leading W by a cycle
        axil_write(32'h1000, 32'hCAFE0001, 1, "wr_first");
        axil_read(32'h1010, "vac_31");
        drain_tx();

        // Overfill TX: 33rd write must be dropped with SLVERR
        for (int i = 0; i < 33; i++) axil_write(32'h1000, $urandom, $urandom_range(0, 2), "wr_fill");
        axil_read(32'h1010, "vac_0");
        drain_tx();

        // RX ordering and empty pop
        rx_push(32'h3AB40000); rx_push(32'h11); rx_push(32'h22);
        axil_read(32'h1018, "occ_3");
        for (int i = 0; i < 4; i++) axil_read(32'h101C, "rx_pop");

        // Fill RX with rx_v_i held, then pop once under back-pressure
        rx_v_i = 1'b1;
        for (int cyc = 0; cyc < 100 && rx_q.size() < RX_ELS; cyc++) begin
            rx_data_i = $urandom;
            tick();
        end
        tick();
        check("rx_full_ready", {31'd0, rx_ready_o}, 32'd0);
        axil_read(32'h101C, "rx_pop_full");
        axil_read(32'h1018, "occ_refill");
        rx_v_i = 1'b0;

        // Error responses
        axil_read(32'h2000, "decerr_rd");
        axil_write(32'h1018, 32'h12345678, 0, "ro_wr");
        axil_read(32'h1018, "occ_after_ro");
        axil_write(32'h3000, 32'h5, 0, "decerr_wr");

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            tx_ready_i = 1'($urandom);
            case ($urandom_range(0, 4))
                0:       axil_write(32'h1000, $urandom, $urandom_range(0, 2), "rnd_wr");
                1:       axil_read(32'h1010, "rnd_vac");
                2:       rx_push($urandom);
                3:       axil_read(32'h101C, "rnd_pop");
                default: axil_read(32'h1018, "rnd_occ");
            endcase
        end
        drain_tx();

        // Held responses with a second write parked in the holding registers
        s_axil_bready_i  = 1'b0;
        s_axil_rready_i  = 1'b0;
        s_axil_awaddr_i  = 32'h1000;
        s_axil_wdata_i   = 32'hD0D0_0001;
        s_axil_awvalid_i = 1'b1;
        s_axil_wvalid_i  = 1'b1;
        s_axil_araddr_i  = 32'h1018;
        s_axil_arvalid_i = 1'b1;
        occ = rx_q.size();
        pend_tx_push = 1'b1;
        pend_tx_data = 32'hD0D0_0001;
        tick();
        s_axil_arvalid_i = 1'b0;
        s_axil_wdata_i   = 32'hD0D0_0002;
        tick();
        s_axil_awvalid_i = 1'b0;
        s_axil_wvalid_i  = 1'b0;
        check("hold_bresp", {30'd0, s_axil_bresp_o}, 32'd0);
        check("hold_rdata", s_axil_rdata_o, occ);
        for (int i = 0; i < 5; i++) begin
            check("hold_bvalid",  {31'd0, s_axil_bvalid_o},  32'd1);
            check("hold_rvalid",  {31'd0, s_axil_rvalid_o},  32'd1);
            check("hold_awready", {31'd0, s_axil_awready_o}, 32'd0);
            check("hold_wready",  {31'd0, s_axil_wready_o},  32'd0);
            check("hold_arready", {31'd0, s_axil_arready_o}, 32'd0);
            tick();
        end

        // Reset mid-hold drops everything, including the parked write
        chk_en  = 1'b0;
        reset_i = 1'b1;
        tick();
        tx_q.delete();
        rx_q.delete();
        check("mrst_bvalid",  {31'd0, s_axil_bvalid_o},  32'd0);
        check("mrst_rvalid",  {31'd0, s_axil_rvalid_o},  32'd0);
        check("mrst_tx_v",    {31'd0, tx_v_o},           32'd0);
        check("mrst_awready", {31'd0, s_axil_awready_o}, 32'd1);
        check("mrst_rx_ready", {31'd0, rx_ready_o},      32'd1);
        reset_i = 1'b0;
        s_axil_bready_i = 1'b1;
        s_axil_rready_i = 1'b1;
        chk_en = 1'b1;
        tick(); tick();
        check("mrst_no_b", {31'd0, s_axil_bvalid_o}, 32'd0);
        axil_read(32'h1018, "mrst_occ");
        axil_read(32'h1010, "mrst_vac");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
